memoria_param: RTL and testbench

Parametrised, clocked successor to the processor's unified instruction/data memory. It serves one request/ready access port for the multicycle datapath (instruction fetch into IR, load into MDR, store from B) and an independent registered debug read port that drives the board displays from the switches. Memory clear-on-reset, configurable wait states and out-of-range detection are built in. Word width, depth and address width are parameters; defaults match the current 16-bit, 50-word, 6-bit-address machine.

---
 rtl/memoria_param.sv | 104 ++++++++++
 tb/tb_memoria_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_param.sv
// memoria_param: parametrised word memory with a req/ready access FSM (clear, wait states,
// out-of-range detection) and an independent registered debug read port.
module memoria_param #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 6,
  parameter int DEPTH          = 50,
  parameter int WAIT_CYCLES    = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic              dbg_en,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, DONE} state_t;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
  localparam logic [3:0]        WLOAD   = 4'(WAIT_CYCLES-1);
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d, mem_addr;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              we_q, we_d, ready_q, ready_d, err_q, err_d, mem_we, in_rng, dbg_rng;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, dbg_q, dbg_d, mem_wdata;
  assign in_rng   = {1'b0, addr_q} < DEPTH_W;
  assign dbg_rng  = {1'b0, dbg_addr} < DEPTH_W;
  assign busy     = (state_q == CLEAR) || (state_q == WAIT);
  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign dbg_data = dbg_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = (state_q == CLEAR) ? cnt_q : addr_q;
    mem_wdata = (state_q == CLEAR) ? '0 : wdata_q;
    case (state_q)
      CLEAR: begin
        cnt_d  = cnt_q + 1'b1;
        mem_we = 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
      end
      IDLE: if (req) begin
        we_d    = we;
        addr_d  = addr;
        wdata_d = wdata;
        wcnt_d  = WLOAD;
        state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
      end
      WAIT: begin
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q == 4'd0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        err_d   = !in_rng;
        mem_we  = we_q && in_rng;
        // rdata only moves on a completed read or any out-of-range access
        if (!we_q || !in_rng) rdata_d = in_rng ? mem[addr_q] : '0;
      end
    endcase
    dbg_d = (dbg_en && state_q != CLEAR && dbg_rng) ? mem[dbg_addr] : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      dbg_q   <= dbg_d;
    end
    wcnt_q  <= wcnt_d;
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    if (mem_we && !reset) mem[mem_addr] <= mem_wdata;
  end
endmodule

// File: tb/tb_memoria_param.sv
// tb_memoria_param: scoreboard bench for two memoria_param builds (no wait/clearing and
// three wait states/no clearing) against an array-based memory model.
module tb_memoria_param;
  typedef struct {
    logic [15:0] rd;
    logic        er;
    int          due;
  } exp_t;
  logic        clock;
  logic        rst [2];
  logic        req [2];
  logic        we [2];
  logic        dbg_en [2];
  logic [5:0]  addr [2];
  logic [5:0]  dbg_addr [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic [15:0] dbg_data [2];
  logic        ready [2];
  logic        err [2];
  logic        busy [2];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wait_of [2] = '{0, 3};
  logic [15:0] mdl [2][64];
  logic [15:0] last_rd [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        mon_e;

  memoria_param #(.WAIT_CYCLES(0), .CLEAR_ON_RESET(1'b1)) u_a (
    .clock(clock), .reset(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]),
    .dbg_en(dbg_en[0]), .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]));
  memoria_param #(.WAIT_CYCLES(3), .CLEAR_ON_RESET(1'b0)) u_b (
    .clock(clock), .reset(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]),
    .dbg_en(dbg_en[1]), .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic int qsize(int k);
    return k == 0 ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(int k);
    return k == 0 ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic exp_t qfront(int k);
    return k == 0 ? q0[0] : q1[0];
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outcome of one access, derived from the memory rules; c_acc is the accepting edge.
  task automatic expect_access(int k, logic w, logic [5:0] a, logic [15:0] d, int c_acc);
    exp_t e;
    if (a >= 6'd50) last_rd[k] = 16'h0;
    else if (w) mdl[k][a] = d;
    else last_rd[k] = mdl[k][a];
    e.rd  = last_rd[k];
    e.er  = (a >= 6'd50);
    e.due = c_acc + 1 + wait_of[k];
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Called on a negedge with the FSM idle; holds req until ready and returns on that negedge.
  task automatic access(int k, logic w, logic [5:0] a, logic [15:0] d);
    req[k] = 1'b1;
    we[k] = w;
    addr[k] = a;
    wdata[k] = d;
    expect_access(k, w, a, d, cyc + 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ready[k]) break;
    end
    if (!ready[k]) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout[%0d]: got no ready expected ready within 40 cycles", k);
    end
    req[k] = 1'b0;
  endtask

  task automatic dbg_chk(logic [5:0] a, string nm);
    dbg_en[0] = 1'b1;
    dbg_addr[0] = a;
    @(negedge clock);
    chk(nm, dbg_data[0], a < 6'd50 ? mdl[0][a] : 16'h0);
    dbg_en[0] = 1'b0;
  endtask

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (ready[k]) begin
        tests++;
        if (qsize(k) == 0) begin
          fails++;
          $display("FAIL unexpected_ready[%0d]: got ready expected none (cycle %0d)", k, cyc);
        end else begin
          mon_e = qpop(k);
          if (rdata[k] !== mon_e.rd || err[k] !== mon_e.er || cyc != mon_e.due) begin
            fails++;
            $display("FAIL access[%0d]: got rdata=%h err=%b cycle=%0d expected rdata=%h err=%b cycle=%0d",
                     k, rdata[k], err[k], cyc, mon_e.rd, mon_e.er, mon_e.due);
          end
        end
      end else begin
        if (err[k] !== 1'b0) begin
          tests++;
          fails++;
          $display("FAIL err_without_ready[%0d]: got err=%b expected 0 (cycle %0d)", k, err[k], cyc);
        end
        if (qsize(k) > 0 && cyc > qfront(k).due) begin
          mon_e = qpop(k);
          tests++;
          fails++;
          $display("FAIL late_ready[%0d]: got none by cycle %0d expected ready at cycle %0d", k, cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    int n;
    int c1;
    logic [5:0] a;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      req[k] = 1'b0;
      we[k] = 1'b0;
      addr[k] = '0;
      wdata[k] = '0;
      dbg_en[k] = 1'b0;
      dbg_addr[k] = '0;
      last_rd[k] = 16'h0;
      for (int i = 0; i < 64; i++) mdl[k][i] = 16'h0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_rdata[%0d]", k), rdata[k], 16'h0);
      chk($sformatf("reset_ready[%0d]", k), {15'h0, ready[k]}, 16'h0);
      chk($sformatf("reset_err[%0d]", k), {15'h0, err[k]}, 16'h0);
      chk($sformatf("reset_dbg[%0d]", k), dbg_data[k], 16'h0);
    end
    chk("reset_busy_a", {15'h0, busy[0]}, 16'h1);
    chk("reset_busy_b", {15'h0, busy[1]}, 16'h0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && busy[0]; i++) begin
      n++;
      @(negedge clock);
    end
    chk("clear_busy_cycles", 16'(n), 16'd50);
    dbg_chk(6'd0, "dbg_clear_0");
    dbg_chk(6'd25, "dbg_clear_25");
    dbg_chk(6'd49, "dbg_clear_49");
    access(0, 1'b1, 6'd5, 16'hABCD);
    access(0, 1'b0, 6'd5, 16'h0);
    chk("read_back_5", rdata[0], 16'hABCD);
    for (int i = 0; i < 40; i++) begin
      a = 6'($urandom_range(0, 63));
      access(0, 1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    access(0, 1'b1, 6'd50, 16'h1234);
    access(0, 1'b0, 6'd50, 16'h0);
    chk("oor_rdata", rdata[0], 16'h0);
    dbg_chk(6'd49, "dbg_49_after_oor");
    dbg_chk(6'd50, "dbg_oor_50");
    access(0, 1'b1, 6'd3, 16'h0011);
    dbg_en[0] = 1'b1;
    dbg_addr[0] = 6'd3;
    access(0, 1'b1, 6'd3, 16'h5555);
    chk("dbg_collision_old", dbg_data[0], 16'h0011);
    @(negedge clock);
    chk("dbg_collision_new", dbg_data[0], 16'h5555);
    dbg_en[0] = 1'b0;
    @(negedge clock);
    chk("dbg_disabled", dbg_data[0], 16'h0);
    for (int i = 0; i < 8; i++) dbg_chk(6'($urandom_range(0, 63)), "dbg_random");

    for (int i = 0; i < 16; i++) access(1, 1'b1, 6'(i), 16'($urandom));
    req[1] = 1'b1;
    we[1] = 1'b0;
    addr[1] = 6'd7;
    c1 = cyc + 1;
    expect_access(1, 1'b0, 6'd7, 16'h0, c1);
    @(negedge clock);
    req[1] = 1'b0;
    chk("wait_busy_1", {15'h0, busy[1]}, 16'h1);
    @(negedge clock);
    chk("wait_busy_2", {15'h0, busy[1]}, 16'h1);
    req[1] = 1'b1;
    addr[1] = 6'd8;
    expect_access(1, 1'b0, 6'd8, 16'h0, c1 + 5);
    @(negedge clock);
    chk("wait_busy_3", {15'h0, busy[1]}, 16'h1);
    @(negedge clock);
    chk("done_not_busy", {15'h0, busy[1]}, 16'h0);
    while (cyc < c1 + 9) @(negedge clock);
    req[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      a = 6'($urandom_range(0, 19));
      if (a >= 6'd16) a = a + 6'd40;
      access(1, 1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    access(1, 1'b1, 6'd9, 16'h00FF);
    req[1] = 1'b1;
    we[1] = 1'b1;
    addr[1] = 6'd9;
    wdata[1] = 16'hBEEF;
    @(negedge clock);
    req[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rst[1] = 1'b0;
    last_rd[1] = 16'h0;
    chk("abort_busy", {15'h0, busy[1]}, 16'h0);
    chk("abort_rdata", rdata[1], 16'h0);
    repeat (8) @(negedge clock);
    access(1, 1'b0, 6'd9, 16'h0);
    chk("abort_mem9", rdata[1], 16'h00FF);
    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
